// File: rtl/pim_seq_pkg.sv
// pim_seq_pkg: shared opcode/state types and instruction field positions for the PIM microsequencer
package pim_seq_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_OP, OP_BRZ, OP_BRNZ, OP_JMP, OP_LDLOOP, OP_DJNZ, OP_HALT
  } opcode_t;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DECODE, S_WAIT_PIM} state_t;
  localparam int OPC_MSB = 15;
  localparam int FSEL_LSB = 9;
  localparam logic [2:0] FSEL_RESERVED = 3'd7;
endpackage

// File: rtl/pim_seq_ctrl_flag_check.sv
// flag_check: reports whether the selected flag bit is zero
module flag_check #(
  parameter int NFLAG = 7
) (
  input  logic [NFLAG-1:0] flags,
  input  logic [2:0]       fsel,
  output logic             eqz
);
  logic [7:0] ext;
  assign ext = 8'(flags);
  assign eqz = ~ext[fsel];
endmodule

// File: rtl/pim_seq_ctrl.sv
// pim_seq_ctrl: fetch/decode microsequencer issuing PIM ops with flag branches and counted loops
module pim_seq_ctrl
  import pim_seq_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int NFLAG   = 7,
  parameter int LOOP_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               pim_issue,
  output logic [11:0]        pim_op,
  input  logic               pim_done,
  input  logic [NFLAG-1:0]   pim_flags,
  output logic [NFLAG-1:0]   flags,
  output logic               busy,
  output logic               done,
  output logic               err
);
  state_t state;
  logic [PC_W-1:0] pc, pc_inc, tgt;
  logic [LOOP_W-1:0] loop_cnt, loop_dec;
  logic [3:0] opc;
  logic [2:0] fsel;
  logic eqz, illegal;
  assign opc = imem_data[OPC_MSB -: 4];
  assign fsel = imem_data[FSEL_LSB +: 3];
  assign tgt = imem_data[PC_W-1:0];
  assign pc_inc = pc + 1'b1;
  assign loop_dec = loop_cnt - 1'b1;
  assign illegal = opc > OP_HALT || ((opc == OP_BRZ || opc == OP_BRNZ) && fsel == FSEL_RESERVED);
  assign imem_addr = pc;
  assign busy = state != S_IDLE;
  flag_check #(.NFLAG(NFLAG)) u_flag_check (.flags(flags), .fsel(fsel), .eqz(eqz));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc <= '0;
      flags <= '0;
      loop_cnt <= '0;
      pim_issue <= 1'b0;
      pim_op <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      pim_issue <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          pc <= '0;
          err <= 1'b0;
          state <= S_FETCH;
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          state <= S_FETCH;
          if (illegal) begin
            err <= 1'b1;
            state <= S_IDLE;
          end else case (opc)
            OP_NOP: pc <= pc_inc;
            OP_OP: begin
              pim_issue <= 1'b1;
              pim_op <= imem_data[11:0];
              state <= S_WAIT_PIM;
            end
            OP_BRZ, OP_BRNZ: pc <= (eqz ^ (opc == OP_BRNZ)) ? tgt : pc_inc;
            OP_JMP: pc <= tgt;
            OP_LDLOOP: begin
              loop_cnt <= tgt[LOOP_W-1:0];
              pc <= pc_inc;
            end
            OP_DJNZ: begin
              if (loop_cnt != '0) loop_cnt <= loop_dec;
              pc <= (loop_cnt != '0 && loop_dec != '0) ? tgt : pc_inc;
            end
            OP_HALT: begin
              done <= 1'b1;
              state <= S_IDLE;
            end
            default: ;
          endcase
        end
        S_WAIT_PIM: if (pim_done && !pim_issue) begin
          flags <= pim_flags;
          pc <= pc_inc;
          state <= S_FETCH;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pim_seq_ctrl.sv
// tb_pim_seq_ctrl: scoreboard bench with directed programs for the PIM microsequencer
module tb_pim_seq_ctrl;
  logic clk = 0, rst = 1, start = 0, resp_done = 0, inj = 0, resp_en = 1;
  logic pim_done, pim_issue, busy, done, err, prev_busy = 0;
  logic [7:0] imem_addr;
  logic [15:0] imem_data;
  logic [11:0] pim_op;
  logic [6:0] pim_flags, flags, resp_flags = 0;
  logic [15:0] mem [256];
  int applied = 0, miscompares = 0, dly = 3;
  typedef struct packed {logic [1:0] k; logic [11:0] d;} ev_t;
  ev_t exp_q[$];
  localparam logic [1:0] K_ISSUE = 2'd0, K_DONE = 2'd1, K_ERR = 2'd2;
  assign pim_done = resp_done | inj;
  assign pim_flags = inj ? 7'h7f : resp_flags;
  always #5 clk = ~clk;
  always @(posedge clk) imem_data <= mem[imem_addr];
  pim_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
    .pim_issue(pim_issue), .pim_op(pim_op), .pim_done(pim_done), .pim_flags(pim_flags),
    .flags(flags), .busy(busy), .done(done), .err(err)
  );
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    applied++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic got(input logic [1:0] k, input logic [11:0] d);
    ev_t e;
    applied++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL event: got kind=%0d data=%h, want no event", k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.k !== k || e.d !== d) begin
        miscompares++;
        $display("FAIL event: got kind=%0d data=%h, want kind=%0d data=%h", k, d, e.k, e.d);
      end
    end
  endtask
  task automatic push(input logic [1:0] k, input logic [11:0] d);
    exp_q.push_back('{k: k, d: d});
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h9000;
  endtask
  task automatic run(input int mid = -1, input logic do_inj = 1'b0);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("busy after start", 16'(busy), 16'd1);
    for (int c = 0; c < 3000 && busy; c++) begin
      start = (c == mid);
      inj = do_inj;
      @(negedge clk);
    end
    start = 0;
    inj = 0;
    if (busy) begin
      chk("run timeout", 16'd1, 16'd0);
      rst = 1;
      @(negedge clk);
      rst = 0;
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    chk("events drained", 16'(exp_q.size()), 16'd0);
  endtask
  initial forever begin
    @(negedge clk);
    if (pim_issue && resp_en) begin
      repeat (dly) @(negedge clk);
      resp_done = 1;
      @(negedge clk);
      resp_done = 0;
    end
  end
  always @(negedge clk) begin
    if (pim_issue === 1'b1) got(K_ISSUE, pim_op);
    if (done === 1'b1) got(K_DONE, {5'b0, flags});
    if (prev_busy && busy === 1'b0 && err === 1'b1) got(K_ERR, 12'h0);
    prev_busy = (busy === 1'b1);
  end
  initial begin
    clear_mem();
    repeat (2) @(negedge clk);
    chk("rst busy", 16'(busy), 16'd0);
    chk("rst flags", 16'(flags), 16'd0);
    chk("rst err", 16'(err), 16'd0);
    chk("rst pc", 16'(imem_addr), 16'd0);
    chk("rst issue", 16'(pim_issue), 16'd0);
    chk("rst done", 16'(done), 16'd0);
    chk("rst pim_op", 16'(pim_op), 16'd0);
    rst = 0;
    @(negedge clk);
    mem[0] = 16'h1123;
    mem[1] = 16'h7000;
    resp_flags = 7'h05;
    dly = 3;
    push(K_ISSUE, 12'h123);
    push(K_DONE, 12'h005);
    run();
    chk("op flags", 16'(flags), 16'h05);
    chk("op err", 16'(err), 16'd0);
    chk("op busy", 16'(busy), 16'd0);
    chk("op halt pc", 16'(imem_addr), 16'd1);
    clear_mem();
    mem[0] = 16'h1000;
    mem[1] = 16'h0000;
    mem[2] = 16'h2410;
    mem[3] = 16'h2020;
    mem[8'h20] = 16'h7000;
    resp_flags = 7'h04;
    dly = 1;
    push(K_ISSUE, 12'h000);
    push(K_DONE, 12'h004);
    run();
    chk("brz pc", 16'(imem_addr), 16'h20);
    chk("brz err", 16'(err), 16'd0);
    clear_mem();
    mem[0] = 16'h1000;
    mem[1] = 16'h3020;
    mem[2] = 16'h3410;
    mem[8'h10] = 16'h7000;
    push(K_ISSUE, 12'h000);
    push(K_DONE, 12'h004);
    run();
    chk("brnz pc", 16'(imem_addr), 16'h10);
    chk("brnz err", 16'(err), 16'd0);
    clear_mem();
    mem[0] = 16'h5003;
    mem[1] = 16'h1abc;
    mem[2] = 16'h6001;
    mem[3] = 16'h7000;
    resp_flags = 7'h11;
    dly = 2;
    for (int i = 0; i < 3; i++) push(K_ISSUE, 12'habc);
    push(K_DONE, 12'h011);
    run(5);
    chk("loop pc", 16'(imem_addr), 16'd3);
    clear_mem();
    mem[0] = 16'h5000;
    mem[1] = 16'h6005;
    mem[2] = 16'h6005;
    mem[3] = 16'h7000;
    push(K_DONE, 12'h011);
    run();
    chk("djnz zero pc", 16'(imem_addr), 16'd3);
    chk("djnz zero err", 16'(err), 16'd0);
    clear_mem();
    push(K_ERR, 12'h0);
    run();
    chk("illegal err", 16'(err), 16'd1);
    chk("illegal pc", 16'(imem_addr), 16'd0);
    chk("illegal flags", 16'(flags), 16'h11);
    clear_mem();
    mem[0] = 16'h2E05;
    mem[5] = 16'h7000;
    push(K_ERR, 12'h0);
    run();
    chk("fsel7 err", 16'(err), 16'd1);
    clear_mem();
    mem[0] = 16'h7000;
    push(K_DONE, 12'h011);
    run();
    chk("err cleared", 16'(err), 16'd0);
    clear_mem();
    mem[0] = 16'h6003;
    mem[1] = 16'h5002;
    mem[2] = 16'h40FF;
    mem[255] = 16'h0000;
    mem[3] = 16'h7000;
    push(K_DONE, 12'h011);
    run(4, 1'b1);
    chk("wrap pc", 16'(imem_addr), 16'd3);
    chk("inject flags", 16'(flags), 16'h11);
    chk("wrap err", 16'(err), 16'd0);
    clear_mem();
    mem[0] = 16'h1055;
    resp_en = 0;
    push(K_ISSUE, 12'h055);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 30 && pim_issue !== 1'b1; c++) @(negedge clk);
    chk("issue seen", 16'(pim_issue), 16'd1);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mid rst busy", 16'(busy), 16'd0);
    chk("mid rst pc", 16'(imem_addr), 16'd0);
    chk("mid rst flags", 16'(flags), 16'd0);
    chk("mid rst issue", 16'(pim_issue), 16'd0);
    rst = 0;
    repeat (10) @(negedge clk);
    chk("post rst idle", 16'(busy), 16'd0);
    chk("post rst events", 16'(exp_q.size()), 16'd0);
    resp_en = 1;
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
